// File: rtl/accum_scan_pkg.sv
// Shared types and the scan operator for accum_scan_engine.
// Contents:
//   MaxDataW  - widest element width the operator supports
//   mode_e    - scan operator select (add / signed max / signed min / xor)
//   state_e   - engine FSM states
//   scan_op() - one accumulate step on sign-extended operands
package accum_scan_pkg;

  localparam int unsigned MaxDataW = 64;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_MAX = 2'd1,
    MODE_MIN = 2'd2,
    MODE_XOR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2
  } state_e;

  // Operands arrive sign-extended to MaxDataW. The low DATA_W bits of the result are
  // then correct for every mode: the add wraps modulo 2^DATA_W and the compares stay signed.
  function automatic logic [MaxDataW-1:0] scan_op(input mode_e m,
                                                  input logic [MaxDataW-1:0] a,
                                                  input logic [MaxDataW-1:0] b);
    logic [MaxDataW-1:0] r;
    r = '0;
    unique case (m)
      MODE_ADD: r = a + b;
      MODE_MAX: r = ($signed(a) > $signed(b)) ? a : b;
      MODE_MIN: r = ($signed(a) < $signed(b)) ? a : b;
      MODE_XOR: r = a ^ b;
      default:  r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/accum_scan_ram.sv
// Single-port synchronous RAM, DATA_W x DEPTH, with a 1-cycle registered read.
// Ports:
//   clk   - clock
//   en    - port enable; when low, no access is made and rdata holds its value
//   we    - write enable (this is a read-old/write port)
//   addr  - word address; addresses >= DEPTH drop writes and read back 0
//   wdata - write data
//   rdata - read data, valid the cycle after an enabled access
module accum_scan_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1000
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  assign in_range = 32'(addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we && in_range) begin
        mem[addr] <= wdata;
      end
      rdata <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/accum_scan_engine.sv
// In-place scan engine: it overwrites len consecutive array elements (wrapping at DEPTH)
// with the running add/max/min/xor of an accumulator seeded by init_acc_t_a.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   r_enable                   - start pulse, sampled in IDLE while controlArr=0
//   mode, len, init_i_t_a,
//   init_acc_t_a               - scan setup, latched at start
//   w_enable                   - 1 = idle/done, 0 = busy
//   result                     - final accumulator
//   ovf                        - sticky signed overflow of the last add-mode scan
//   controlArr                 - 1 = host owns the array port and the engine stalls
//   controlArrWEnable_a,
//   controlArrAddr_a,
//   controlArrWData_a          - host write enable / address / write data
//   controlArrRData_a          - array read data, 1-cycle latency
module accum_scan_engine
  import accum_scan_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_enable,
  input  logic [1:0]        mode,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] init_i_t_a,
  input  logic [DATA_W-1:0] init_acc_t_a,
  output logic              w_enable,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  input  logic              controlArr,
  input  logic              controlArrWEnable_a,
  input  logic [ADDR_W-1:0] controlArrAddr_a,
  input  logic [DATA_W-1:0] controlArrWData_a,
  output logic [DATA_W-1:0] controlArrRData_a
);

  localparam logic [ADDR_W:0]   DepthLen = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [ADDR_W:0]   len_q, cnt_q, cnt_inc;
  logic [ADDR_W-1:0] idx_q, idx_next;
  logic [DATA_W-1:0] acc_q, acc_n, result_q;
  logic              ovf_q, zpulse_q;

  logic              start, len_zero, last, wr_fire, ovf_hit;
  logic [MaxDataW-1:0] op_r;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // zpulse_q marks the single busy cycle of a len=0 scan; a new start is refused meanwhile.
  assign start    = (state_q == StIdle) && r_enable && !controlArr && !zpulse_q;
  assign len_zero = (len == '0);
  assign cnt_inc  = cnt_q + 1'b1;
  assign last     = (cnt_inc == len_q);
  assign wr_fire  = (state_q == StWr) && !controlArr;
  assign idx_next = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

  assign op_r  = scan_op(mode_q, MaxDataW'($signed(acc_q)), MaxDataW'($signed(ram_rdata)));
  assign acc_n = op_r[DATA_W-1:0];

  assign ovf_hit = (mode_q == MODE_ADD) &&
                   (acc_q[DATA_W-1] == ram_rdata[DATA_W-1]) &&
                   (acc_n[DATA_W-1] != acc_q[DATA_W-1]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A stall in WR falls back to RD because the host has taken over the
  // RAM read port and the engine's read data is no longer valid.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && !len_zero) state_d = StRd;
      StRd:   if (!controlArr) state_d = StWr;
      StWr: begin
        if (controlArr)  state_d = StRd;
        else if (last)   state_d = StIdle;
        else             state_d = StRd;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and the host/engine RAM port mux
  always_comb begin
    w_enable  = (state_q == StIdle) && !zpulse_q;
    ram_en    = controlArr || (state_q != StIdle);
    ram_we    = controlArr ? controlArrWEnable_a : (state_q == StWr);
    ram_addr  = controlArr ? controlArrAddr_a : idx_q;
    ram_wdata = controlArr ? controlArrWData_a : acc_n;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_ADD;
      len_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zpulse_q <= 1'b0;
    end else begin
      zpulse_q <= start && len_zero;
      if (start) begin
        mode_q <= mode_e'(mode);
        len_q  <= (len > DepthLen) ? DepthLen : len;
        cnt_q  <= '0;
        idx_q  <= init_i_t_a;
        acc_q  <= init_acc_t_a;
        ovf_q  <= 1'b0;
        if (len_zero) begin
          result_q <= init_acc_t_a;
        end
      end else if (wr_fire) begin
        acc_q <= acc_n;
        idx_q <= idx_next;
        cnt_q <= cnt_inc;
        if (ovf_hit) begin
          ovf_q <= 1'b1;
        end
        if (last) begin
          result_q <= acc_n;
        end
      end
    end
  end

  assign result            = result_q;
  assign ovf               = ovf_q;
  assign controlArrRData_a = ram_rdata;

  accum_scan_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_accum_scan_engine.sv
// Directed bench for accum_scan_engine at the default 64-bit / 1000-entry configuration.
module tb_accum_scan_engine;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;
  localparam int LIMIT = 5000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          r_enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] init_i = '0;
  logic [DW-1:0] init_acc = '0;
  logic          w_enable;
  logic [DW-1:0] result;
  logic          ovf;
  logic          ctrl = 1'b0;
  logic          h_we = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic [DW-1:0] h_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_mem [DEPTH];

  always #5 clk = ~clk;

  accum_scan_engine #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .r_enable           (r_enable),
    .mode               (mode),
    .len                (len),
    .init_i_t_a         (init_i),
    .init_acc_t_a       (init_acc),
    .w_enable           (w_enable),
    .result             (result),
    .ovf                (ovf),
    .controlArr         (ctrl),
    .controlArrWEnable_a(h_we),
    .controlArrAddr_a   (h_addr),
    .controlArrWData_a  (h_wdata),
    .controlArrRData_a  (h_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hwrite(input int a, input logic [DW-1:0] d);
    ctrl    = 1'b1;
    h_we    = 1'b1;
    h_addr  = AW'(a);
    h_wdata = d;
    tick();
    h_we = 1'b0;
    ctrl = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic hread(input int a, output logic [DW-1:0] d);
    ctrl   = 1'b1;
    h_we   = 1'b0;
    h_addr = AW'(a);
    tick();
    d    = h_rdata;
    ctrl = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input int a);
    logic [DW-1:0] d;
    hread(a, d);
    chk(tag, d, exp_mem[a]);
  endtask

  task automatic start(input int m, input int l, input int ii, input logic [DW-1:0] acc);
    mode     = 2'(m);
    len      = (AW + 1)'(l);
    init_i   = AW'(ii);
    init_acc = acc;
    r_enable = 1'b1;
    tick();
    r_enable = 1'b0;
  endtask

  // Counts cycles with w_enable low after the start edge.
  task automatic wait_done(output int n);
    n = 0;
    while (w_enable !== 1'b1 && n < LIMIT) begin
      n++;
      tick();
    end
    if (n >= LIMIT) chk("wait_done_timeout", 64'(w_enable), 64'd1);
  endtask

  initial begin
    int            n;
    logic [DW-1:0] v, sum;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_w_enable", 64'(w_enable), 64'd1);
    chk("rst_result", result, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Prefix sum over all 1000 entries
    sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v = 64'($signed($urandom()));
      hwrite(k, v);
      sum = sum + v;
      exp_mem[k] = sum;
    end
    start(0, 1000, 0, '0);
    wait_done(n);
    chk("prefix_busy", 64'(n), 64'd2000);
    chk("prefix_result", result, sum);
    chk("prefix_ovf", 64'(ovf), 64'd0);
    for (int k = 0; k < DEPTH; k++) chk_mem($sformatf("prefix_mem%0d", k), k);

    // Signed overflow in add mode, then cleared by a max-mode scan
    hwrite(0, 64'h7FFF_FFFF_FFFF_FFFF);
    hwrite(1, 64'd1);
    start(0, 2, 0, '0);
    wait_done(n);
    chk("ovf_busy", 64'(n), 64'd4);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_result", result, 64'h8000_0000_0000_0000);
    exp_mem[1] = 64'h8000_0000_0000_0000;
    chk_mem("ovf_mem0", 0);
    chk_mem("ovf_mem1", 1);
    hwrite(5, -64'sd9);
    start(1, 1, 5, '0);
    wait_done(n);
    chk("ovf_cleared", 64'(ovf), 64'd0);
    chk("max1_result", result, 64'd0);
    exp_mem[5] = 64'd0;
    chk_mem("max1_mem5", 5);

    // Address wrap with signed max
    hwrite(998, 64'd5);
    hwrite(999, -64'sd7);
    hwrite(0, 64'd20);
    hwrite(1, 64'd3);
    start(1, 4, 998, -64'sd100);
    wait_done(n);
    chk("wrap_busy", 64'(n), 64'd8);
    chk("wrap_result", result, 64'd20);
    exp_mem[998] = 64'd5;
    exp_mem[999] = 64'd5;
    exp_mem[0]   = 64'd20;
    exp_mem[1]   = 64'd20;
    chk_mem("wrap_mem998", 998);
    chk_mem("wrap_mem999", 999);
    chk_mem("wrap_mem0", 0);
    chk_mem("wrap_mem1", 1);
    chk_mem("wrap_keep2", 2);
    chk_mem("wrap_keep500", 500);
    chk_mem("wrap_keep997", 997);

    // len = 0: one busy cycle, result = seed, no writes
    start(0, 0, 7, 64'h1234);
    wait_done(n);
    chk("len0_busy", 64'(n), 64'd1);
    chk("len0_result", result, 64'h1234);
    chk_mem("len0_mem7", 7);

    // Start while the host owns the array is ignored
    ctrl     = 1'b1;
    r_enable = 1'b1;
    mode     = 2'd0;
    len      = (AW + 1)'(3);
    tick();
    chk("ctrl_start_w0", 64'(w_enable), 64'd1);
    tick();
    chk("ctrl_start_w1", 64'(w_enable), 64'd1);
    r_enable = 1'b0;
    ctrl     = 1'b0;
    tick();
    chk("ctrl_start_w2", 64'(w_enable), 64'd1);
    chk("ctrl_start_result", result, 64'h1234);

    // Five-cycle host stall in the middle of an xor scan
    hwrite(10, 64'd1);
    hwrite(11, 64'd2);
    hwrite(12, 64'd4);
    hwrite(13, 64'd8);
    hwrite(14, 64'd16);
    hwrite(15, 64'd32);
    start(3, 6, 10, '0);
    n = 0;
    while (w_enable !== 1'b1 && n < LIMIT) begin
      n++;
      if (n == 3) ctrl = 1'b1;
      if (n == 8) ctrl = 1'b0;
      tick();
    end
    ctrl = 1'b0;
    chk("stall_busy", 64'(n), 64'd17);
    chk("stall_result", result, 64'd63);
    chk("stall_ovf", 64'(ovf), 64'd0);
    exp_mem[10] = 64'd1;
    exp_mem[11] = 64'd3;
    exp_mem[12] = 64'd7;
    exp_mem[13] = 64'd15;
    exp_mem[14] = 64'd31;
    exp_mem[15] = 64'd63;
    for (int k = 10; k < 16; k++) chk_mem($sformatf("stall_mem%0d", k), k);

    // Reset mid-scan: the first two elements are written, the rest stay untouched
    hwrite(20, 64'd10);
    hwrite(21, 64'd20);
    hwrite(22, 64'd30);
    hwrite(23, 64'd40);
    hwrite(24, 64'd50);
    hwrite(25, 64'd60);
    start(0, 6, 20, '0);
    repeat (4) tick();
    chk("abort_busy_before", 64'(w_enable), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_w_enable", 64'(w_enable), 64'd1);
    chk("abort_result", result, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_mem[20] = 64'd10;
    exp_mem[21] = 64'd30;
    for (int k = 20; k < 26; k++) chk_mem($sformatf("abort_mem%0d", k), k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_scan_engine.md
Name: accum_scan_engine

Overview:
- Parametrised in-place scan engine over an internal single-port array.
- Host loads the array through a muxed port while controlArr=1. A start pulse then runs a scan over `len` elements from `init_i_t_a`, seeded with `init_acc_t_a`.
- Each element is overwritten with the running result. The mode selects add, signed max, signed min or xor.
- Generalises the fixed 64-bit/1000-entry prefix-sum main: width, depth and mode are configurable, with overflow flag, address wrap and controlArr stall.

Parameters:
DATA_W, 64, element/accumulator width (signed)
ADDR_W, 10, array address width
DEPTH, 1000, array entries (must be <= 2**ADDR_W)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
r_enable  input  1  start pulse; sampled only in IDLE
mode  input  2  0=add, 1=signed max, 2=signed min, 3=xor; latched at start
len  input  ADDR_W+1  element count, 0..DEPTH; latched at start
init_i_t_a  input  ADDR_W  first index; latched at start
init_acc_t_a  input  DATA_W  initial accumulator; latched at start
w_enable  output  1  1 = idle/done, 0 = busy
result  output  DATA_W  final accumulator; valid while w_enable=1
ovf  output  1  sticky signed overflow of the last add-mode scan
controlArr  input  1  1 = host owns the array port
controlArrWEnable_a  input  1  host write enable
controlArrAddr_a  input  ADDR_W  host address
controlArrWData_a  input  DATA_W  host write data
controlArrRData_a  output  DATA_W  read data, 1-cycle synchronous latency (host and engine)

Behaviour:
Reset (async, rst_n=0):
- state=IDLE, w_enable=1, result=0, ovf=0, internal acc/index/count=0.
- Array contents are not reset. Reset during a scan aborts it; elements already written keep their new values.

States: IDLE, RD, WR.

IDLE:
- r_enable=1 and controlArr=0: latch mode/len/init_i_t_a/init_acc_t_a; acc=init_acc_t_a; ovf=0.
- If len=0: result=init_acc_t_a and w_enable=0 for exactly one cycle, no array access. Otherwise go to RD, w_enable=0.
- r_enable while controlArr=1 is ignored.

RD:
- Array read at index i; go to WR.

WR:
- acc_n = op(acc, rdata); write acc_n to index i; acc=acc_n.
- i = (i==DEPTH-1) ? 0 : i+1 (wrap); cnt++.
- If cnt reaches len: result=acc_n, go to IDLE, w_enable=1 on the following cycle. Else go to RD.

Timing and ordering:
- Busy window = 2*len cycles (w_enable low from the cycle after start through the final WR).
- Element k's write lands before element k+1's read; no forwarding needed.

Arithmetic:
- add: two's-complement wrap mod 2^DATA_W. ovf |= (sign(a)==sign(b) && sign(sum)!=sign(a)).
- max/min: signed compare. xor: bitwise.
- ovf stays 0 in modes other than add.

Stall and host port:
- controlArr=1 while busy freezes state, acc, i and cnt, with no engine array access.
- A read issued in RD is re-issued after the stall (RD is re-entered); WR is taken only when controlArr=0.
- Host port is honoured whenever controlArr=1, in any state.
- Host addresses >= DEPTH: writes dropped, reads return 0.

Other boundaries:
- r_enable while busy: ignored.
- len > DEPTH: clamped to DEPTH at latch.

Decomposition:
- Package accum_scan_pkg: mode enum (MODE_ADD, MODE_MAX, MODE_MIN, MODE_XOR), state enum, op function.
- Sub-module accum_scan_ram: single-port synchronous RAM (DATA_W x DEPTH, 1-cycle read) with the host/engine mux outside it.

Test Plan:
- Prefix sum, random 32-bit signed values into 1000 entries, mode=0, init 0/0, len=1000:
  - array[k] = sum of values 0..k; result = total.
  - Busy window 2000 cycles; ovf=0.
- Overflow, DATA_W=64: array[0]=2^63-1, array[1]=1, mode=0, len=2:
  - array[1]=-2^63, ovf=1.
  - Next scan with mode=1 clears ovf to 0.
- Wrap and max: init_i_t_a=998, len=4, mode=1, init_acc=-100; values at 998,999,0,1 = 5,-7,20,3:
  - Written 5,5,20,20; result=20.
  - Indices 2..997 unchanged.
- len=0 and start under controlArr=1:
  - len=0 gives w_enable low exactly 1 cycle, result=init_acc_t_a, no writes.
  - r_enable with controlArr=1 gives w_enable staying high.
- Stall and reset:
  - controlArr raised for 5 cycles mid-scan (mode=3): final xor values still correct; busy window extended by 5 cycles.
  - rst_n pulsed mid-scan: w_enable=1, result=0 immediately; elements before the abort point are updated, the rest are untouched.
